// File: rtl/sprite_slot_pkg.sv
// Shared types and helpers for the sprite slot renderer.
package sprite_slot_pkg;

  localparam int COLOR_W = 4;
  localparam int COORD_W = 10;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  typedef struct packed {
    logic               vis;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    dir_t               dir;
  } slot_t;

  // Span test widened by one bit so origin+len cannot wrap at the top of the coordinate range.
  function automatic logic in_span(input logic [COORD_W-1:0] p,
                                   input logic [COORD_W-1:0] o,
                                   input logic [COORD_W:0]   len);
    logic [COORD_W:0] p_w;
    logic [COORD_W:0] o_w;
    p_w = {1'b0, p};
    o_w = {1'b0, o};
    return (p_w >= o_w) && (p_w < (o_w + len));
  endfunction

  // True when two or more bits are set (up to 8 slots).
  function automatic logic multi_hot8(input logic [7:0] v);
    return (v & (v - 8'd1)) != 8'd0;
  endfunction

endpackage

// File: rtl/sprite_slot_hit.sv
// Per-slot bounding-box hit test and rotation of the in-sprite offset to ROM (u,v).
module sprite_slot_hit
  import sprite_slot_pkg::*;
#(
  parameter int SPRITE_W = 8,
  parameter int AW       = $clog2(SPRITE_W)
) (
  input  slot_t              slot,
  input  logic [COORD_W-1:0] draw_x,
  input  logic [COORD_W-1:0] draw_y,
  output logic               hit,
  output logic [AW-1:0]      u,
  output logic [AW-1:0]      v
);

  localparam logic [AW-1:0] S = AW'(SPRITE_W - 1);

  logic [AW-1:0] dx;
  logic [AW-1:0] dy;

  // Hit test plus direction-dependent remap of (dx,dy).
  always_comb begin
    hit = slot.vis &&
          in_span(draw_x, slot.x, (COORD_W + 1)'(SPRITE_W)) &&
          in_span(draw_y, slot.y, (COORD_W + 1)'(SPRITE_W));
    dx  = AW'(draw_x - slot.x);
    dy  = AW'(draw_y - slot.y);
    case (slot.dir)
      DIR_UP:    begin u = dx;     v = dy;     end
      DIR_RIGHT: begin u = dy;     v = S - dx; end
      DIR_DOWN:  begin u = S - dx; v = S - dy; end
      DIR_LEFT:  begin u = S - dy; v = dx;     end
      default:   begin u = dx;     v = dy;     end
    endcase
  end

endmodule

// File: rtl/sprite_slot_renderer.sv
// Multi-slot sprite renderer in the VGA colour path, fixed 2-cycle pixel latency.
// Optional per-slot overlap flags on port collide when SPRITE_COLLIDE_EN is defined.
module sprite_slot_renderer
  import sprite_slot_pkg::*;
#(
  parameter int NUM_SLOTS  = 4,
  parameter int SPRITE_W   = 8,
  parameter int IDX_W      = 1,
  parameter int TRANSP_IDX = 0,
  parameter int V_ACTIVE   = 480
) (
  input  logic                                             vga_clk,
  input  logic                                             reset,
  input  logic [9:0]                                       DrawX,
  input  logic [9:0]                                       DrawY,
  input  logic                                             blank,
  input  logic                                             wr_en,
  input  logic [((NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1)-1:0] wr_slot,
  input  logic [9:0]                                       wr_x,
  input  logic [9:0]                                       wr_y,
  input  logic [1:0]                                       wr_dir,
  input  logic                                             wr_vis,
  output logic [2*$clog2(SPRITE_W)-1:0]                    rom_addr,
  input  logic [IDX_W-1:0]                                 rom_q,
  output logic [IDX_W-1:0]                                 pal_index,
  input  logic [COLOR_W-1:0]                               pal_red,
  input  logic [COLOR_W-1:0]                               pal_green,
  input  logic [COLOR_W-1:0]                               pal_blue,
  input  logic [COLOR_W-1:0]                               bg_red,
  input  logic [COLOR_W-1:0]                               bg_green,
  input  logic [COLOR_W-1:0]                               bg_blue,
  output logic [COLOR_W-1:0]                               red,
  output logic [COLOR_W-1:0]                               green,
  output logic [COLOR_W-1:0]                               blue
`ifdef SPRITE_COLLIDE_EN
  ,
  output logic [NUM_SLOTS-1:0]                             collide
`endif
);

  localparam int         AW      = $clog2(SPRITE_W);
  localparam int         RGB_W   = 3 * COLOR_W;
  localparam logic [9:0] LATCH_Y = 10'(V_ACTIVE);

  slot_t [NUM_SLOTS-1:0] shadow_q, shadow_d;
  slot_t [NUM_SLOTS-1:0] active_q, active_d;

  logic                 frame_latch;
  logic [NUM_SLOTS-1:0] hit_vec;
  logic [AW-1:0]        u_arr [NUM_SLOTS];
  logic [AW-1:0]        v_arr [NUM_SLOTS];
  logic                 win_hit;
  logic [AW-1:0]        win_u;
  logic [AW-1:0]        win_v;

  logic             hit_q, hit_d;
  logic             blank_q, blank_d;
  logic [RGB_W-1:0] bg_q, bg_d;
  logic [RGB_W-1:0] rgb_q, rgb_d;

  assign frame_latch = (DrawX == 10'd0) && (DrawY == LATCH_Y);

  // Shadow takes CPU writes; active copies the pre-write shadow at the frame boundary.
  always_comb begin
    shadow_d = shadow_q;
    if (frame_latch) begin
      active_d = shadow_q;
    end else begin
      active_d = active_q;
    end
    if (wr_en && (int'(wr_slot) < NUM_SLOTS)) begin
      shadow_d[wr_slot] = '{vis: wr_vis, x: wr_x, y: wr_y, dir: dir_t'(wr_dir)};
    end else begin
      shadow_d = shadow_q;
    end
  end

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    sprite_slot_hit #(
      .SPRITE_W(SPRITE_W),
      .AW      (AW)
    ) u_hit (
      .slot  (active_q[i]),
      .draw_x(DrawX),
      .draw_y(DrawY),
      .hit   (hit_vec[i]),
      .u     (u_arr[i]),
      .v     (v_arr[i])
    );
  end

  // Lowest-index hitting slot owns the pixel; scanning downward lets it overwrite the rest.
  always_comb begin
    win_hit = 1'b0;
    win_u   = '0;
    win_v   = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      win_hit = win_hit | hit_vec[i];
      win_u   = hit_vec[i] ? u_arr[i] : win_u;
      win_v   = hit_vec[i] ? v_arr[i] : win_v;
    end
    rom_addr = win_hit ? {win_v, win_u} : '0;
  end

  assign pal_index = rom_q;

  // Stage-1 delay of hit/blank/bg and stage-2 colour select.
  always_comb begin
    hit_d   = win_hit;
    blank_d = blank;
    bg_d    = {bg_red, bg_green, bg_blue};
    if (!blank_q) begin
      rgb_d = '0;
    end else if (hit_q && (rom_q != IDX_W'(TRANSP_IDX))) begin
      rgb_d = {pal_red, pal_green, pal_blue};
    end else begin
      rgb_d = bg_q;
    end
  end

  // Slot state and pixel pipeline registers.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      shadow_q <= '0;
      active_q <= '0;
      hit_q    <= 1'b0;
      blank_q  <= 1'b0;
      bg_q     <= '0;
      rgb_q    <= '0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      hit_q    <= hit_d;
      blank_q  <= blank_d;
      bg_q     <= bg_d;
      rgb_q    <= rgb_d;
    end
  end

  assign red   = rgb_q[RGB_W-1:2*COLOR_W];
  assign green = rgb_q[2*COLOR_W-1:COLOR_W];
  assign blue  = rgb_q[COLOR_W-1:0];

`ifdef SPRITE_COLLIDE_EN
  logic [NUM_SLOTS-1:0] acc_q, acc_d;
  logic [NUM_SLOTS-1:0] collide_q, collide_d;
  logic                 multi_hit;

  // Sticky overlap accumulator, published and cleared at the frame boundary.
  always_comb begin
    multi_hit = multi_hot8(8'(hit_vec));
    if (frame_latch) begin
      collide_d = acc_q;
      acc_d     = '0;
    end else if (blank && multi_hit) begin
      collide_d = collide_q;
      acc_d     = acc_q | hit_vec;
    end else begin
      collide_d = collide_q;
      acc_d     = acc_q;
    end
  end

  // Collision registers.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      acc_q     <= '0;
      collide_q <= '0;
    end else begin
      acc_q     <= acc_d;
      collide_q <= collide_d;
    end
  end

  assign collide = collide_q;
`endif

endmodule

// File: tb/tb_sprite_slot_renderer.sv
// Bench for sprite_slot_renderer: table-driven pixels, scoreboard queue, 2-cycle latency.
module tb_sprite_slot_renderer;

  localparam int K_NONE = 0;
  localparam int K_BG   = 1;
  localparam int K_SP   = 2;
  localparam int K_ZERO = 3;
  localparam logic [11:0] SP_RGB = 12'hFA5;

  typedef struct {
    int    x;
    int    y;
    int    kind;
    string nm;
  } vec_t;

  typedef struct {
    logic        chk;
    logic [11:0] exp;
    logic        col_chk;
    logic [3:0]  col_exp;
    string       nm;
  } exp_t;

  logic       vga_clk;
  logic       reset;
  logic [9:0] DrawX, DrawY;
  logic       blank;
  logic       wr_en;
  logic [1:0] wr_slot;
  logic [9:0] wr_x, wr_y;
  logic [1:0] wr_dir;
  logic       wr_vis;
  logic [5:0] rom_addr;
  logic [0:0] rom_q = 1'b0;
  logic [0:0] pal_index;
  logic [3:0] pal_red, pal_green, pal_blue;
  logic [3:0] bg_red, bg_green, bg_blue;
  logic [3:0] red, green, blue;
`ifdef SPRITE_COLLIDE_EN
  logic [3:0] collide;
`endif

  logic       rom_mem [64];
  vec_t       tbl [$];
  exp_t       sb [$];
  int         n_pass = 0;
  int         n_total = 0;
  logic       pend_col_chk = 1'b0;
  logic [3:0] pend_col_exp = 4'd0;

  sprite_slot_renderer dut (
    .vga_clk  (vga_clk),
    .reset    (reset),
    .DrawX    (DrawX),
    .DrawY    (DrawY),
    .blank    (blank),
    .wr_en    (wr_en),
    .wr_slot  (wr_slot),
    .wr_x     (wr_x),
    .wr_y     (wr_y),
    .wr_dir   (wr_dir),
    .wr_vis   (wr_vis),
    .rom_addr (rom_addr),
    .rom_q    (rom_q),
    .pal_index(pal_index),
    .pal_red  (pal_red),
    .pal_green(pal_green),
    .pal_blue (pal_blue),
    .bg_red   (bg_red),
    .bg_green (bg_green),
    .bg_blue  (bg_blue),
    .red      (red),
    .green    (green),
    .blue     (blue)
`ifdef SPRITE_COLLIDE_EN
    ,
    .collide  (collide)
`endif
  );

  initial begin
    vga_clk = 1'b0;
    forever #5 vga_clk = ~vga_clk;
  end

  // One-cycle-latency sprite ROM and combinational palette.
  always @(posedge vga_clk) rom_q <= rom_mem[rom_addr];
  assign {pal_red, pal_green, pal_blue} = (pal_index == 1'b1) ? SP_RGB : 12'h123;

  function automatic logic [11:0] bgc(input logic [9:0] x, input logic [9:0] y);
    return {x[3:0] ^ 4'h3, y[3:0], 4'hC};
  endfunction

  // Output is due two edges after a pixel is driven, i.e. when three records are queued.
  always @(negedge vga_clk) begin
    if (sb.size() >= 3) begin
      exp_t r;
      r = sb.pop_front();
      if (r.chk) begin
        n_total++;
        if ({red, green, blue} === r.exp) n_pass++;
        else $display("FAIL %s: rgb=%03h expected %03h", r.nm, {red, green, blue}, r.exp);
      end
`ifdef SPRITE_COLLIDE_EN
      if (r.col_chk) begin
        n_total++;
        if (collide === r.col_exp) n_pass++;
        else $display("FAIL %s_collide: collide=%b expected %b", r.nm, collide, r.col_exp);
      end
`endif
    end
  end

  task automatic add(input int x, input int y, input int kind, input string nm);
    vec_t v;
    v.x = x; v.y = y; v.kind = kind; v.nm = nm;
    tbl.push_back(v);
  endtask

  task automatic step(input int x, input int y, input logic bl, input int kind, input string nm);
    exp_t r;
    DrawX = 10'(x);
    DrawY = 10'(y);
    blank = bl;
    {bg_red, bg_green, bg_blue} = bgc(10'(x), 10'(y));
    r.nm      = nm;
    r.chk     = (kind != K_NONE);
    r.col_chk = pend_col_chk;
    r.col_exp = pend_col_exp;
    case (kind)
      K_SP:    r.exp = SP_RGB;
      K_BG:    r.exp = bgc(10'(x), 10'(y));
      default: r.exp = 12'h000;
    endcase
    sb.push_back(r);
    pend_col_chk = 1'b0;
    @(posedge vga_clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic wr(input int s, input int x, input int y, input int d, input logic vis);
    wr_en   = 1'b1;
    wr_slot = 2'(s);
    wr_x    = 10'(x);
    wr_y    = 10'(y);
    wr_dir  = 2'(d);
    wr_vis  = vis;
  endtask

  task automatic col_expect(input logic [3:0] e);
    pend_col_chk = 1'b1;
    pend_col_exp = e;
  endtask

  task automatic latch();
    step(0, 480, 1'b0, K_ZERO, "latch_blank");
  endtask

  task automatic idle();
    step(20, 20, 1'b1, K_BG, "idle_bg");
  endtask

  task automatic run(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) step(tbl[i].x, tbl[i].y, 1'b1, tbl[i].kind, tbl[i].nm);
  endtask

  initial begin
    add(100, 50, K_SP, "d0_origin");      // 0
    add(101, 50, K_BG, "d0_right");       // 1
    add(100, 51, K_BG, "d0_below");       // 2
    add(99,  50, K_BG, "d0_left_out");    // 3
    add(107, 50, K_SP, "d1_px");          // 4
    add(100, 50, K_BG, "d1_origin_bg");   // 5
    add(107, 57, K_SP, "d2_px");          // 6
    add(107, 50, K_BG, "d2_other_bg");    // 7
    add(100, 57, K_SP, "d3_px");          // 8
    add(107, 57, K_BG, "d3_other_bg");    // 9
    add(636, 200, K_SP, "clip_origin");   // 10
    add(639, 200, K_BG, "clip_edge");     // 11
    add(0,   200, K_BG, "clip_nowrap0");  // 12
    add(1,   200, K_BG, "clip_nowrap1");  // 13
    add(2,   200, K_BG, "clip_nowrap2");  // 14
    add(3,   200, K_BG, "clip_nowrap3");  // 15
    add(400, 100, K_SP, "prio_slot0");    // 16
    add(407, 107, K_BG, "prio_transp");   // 17
    add(406, 107, K_BG, "prio_transp2");  // 18

    for (int i = 0; i < 64; i++) rom_mem[i] = 1'b0;
    rom_mem[0] = 1'b1;
    wr_en = 1'b0; wr_slot = 2'd0; wr_x = 10'd0; wr_y = 10'd0; wr_dir = 2'd0; wr_vis = 1'b0;

    reset = 1'b1;
    for (int i = 0; i < 4; i++) step(20, 20, 1'b1, K_ZERO, "reset_out");
    reset = 1'b0;
`ifdef SPRITE_COLLIDE_EN
    col_expect(4'b0000);
`endif
    step(30, 30, 1'b1, K_BG, "post_reset_bg");

    wr(0, 100, 50, 0, 1'b1); step(100, 50, 1'b1, K_BG, "pre_latch_bg");
    latch(); run(0, 3);
    wr(0, 100, 50, 1, 1'b1); idle(); latch(); run(4, 5);
    wr(0, 100, 50, 2, 1'b1); idle(); latch(); run(6, 7);
    wr(0, 100, 50, 3, 1'b1); idle(); latch(); run(8, 9);

    wr(0, 200, 50, 0, 1'b1); step(10, 240, 1'b1, K_BG, "tear_write");
    step(100, 57, 1'b1, K_SP, "tear_old_kept");
    step(200, 50, 1'b1, K_BG, "tear_new_hidden");
    latch();
    step(200, 50, 1'b1, K_SP, "tear_new_shown");
    step(100, 57, 1'b1, K_BG, "tear_old_gone");
    wr(0, 300, 50, 0, 1'b1); latch();
    step(300, 50, 1'b1, K_BG, "samecyc_hidden");
    step(200, 50, 1'b1, K_SP, "samecyc_old_kept");
    latch();
    step(300, 50, 1'b1, K_SP, "samecyc_shown");

    wr(0, 400, 100, 0, 1'b1); idle();
    wr(1, 636, 200, 0, 1'b1); idle();
    latch(); run(10, 15);
    wr(1, 400, 100, 2, 1'b1); idle(); latch(); run(16, 18);
    wr(0, 400, 100, 0, 1'b0); idle(); latch();
    step(407, 107, 1'b1, K_SP, "slot1_alone");
    step(400, 100, 1'b1, K_BG, "slot0_hidden");

    step(407, 107, 1'b0, K_ZERO, "blank_sprite");
    step(10, 10, 1'b0, K_ZERO, "blank_bg");
    step(407, 107, 1'b1, K_SP, "unblank");

    step(407, 107, 1'b1, K_SP, "pre_reset_sprite");
    step(20, 240, 1'b1, K_ZERO, "reset_edge");
    reset = 1'b1;
    for (int i = 0; i < 3; i++) step(407, 240, 1'b1, K_ZERO, "midframe_reset");
    reset = 1'b0;
`ifdef SPRITE_COLLIDE_EN
    col_expect(4'b0000);
`endif
    step(407, 107, 1'b1, K_BG, "post_reset_cleared");
    latch();
    step(407, 107, 1'b1, K_BG, "post_reset_latch_bg");

    wr(3, 50, 60, 0, 1'b1); idle(); latch();
    step(50, 60, 1'b1, K_SP, "slot3_hit");
    step(51, 60, 1'b1, K_BG, "slot3_bg");

`ifdef SPRITE_COLLIDE_EN
    wr(0, 300, 300, 0, 1'b1); idle();
    wr(2, 304, 304, 0, 1'b1); idle();
    wr(1, 10, 10, 0, 1'b1); idle();
    wr(3, 50, 60, 0, 1'b0); idle();
    latch();
    col_expect(4'b0000);
    step(305, 305, 1'b1, K_BG, "col_overlap_px");
    step(300, 300, 1'b1, K_SP, "col_slot0_px");
    step(12, 12, 1'b1, K_BG, "col_slot1_px");
    wr(2, 500, 300, 0, 1'b1); latch();
    col_expect(4'b0101);
    step(305, 305, 1'b1, K_BG, "col_flags_set");
    col_expect(4'b0101);
    step(504, 300, 1'b1, K_BG, "col_flags_hold");
    idle();
    latch();
    col_expect(4'b0000);
    step(20, 20, 1'b1, K_BG, "col_flags_clear");
`endif

    for (int i = 0; i < 3; i++) step(20, 20, 1'b1, K_NONE, "flush");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sprite_slot_renderer.md
Name: sprite_slot_renderer

Overview:
- Next-generation sprite renderer. It draws up to NUM_SLOTS copies of one square sprite bitmap (bullets, shells) at independent screen positions.
- Each slot has its own position, direction (0/90/180/270 rotation) and visibility.
- Transparent pixels pass the background through, and the block inserts into the VGA colour path.
- Slot state is double-buffered, and new values take effect only at the frame boundary, so a frame never tears.

Parameters:
- NUM_SLOTS, 4, number of independent sprite slots (1..8).
- SPRITE_W, 8, sprite width and height in pixels; must be a power of two.
- IDX_W, 1, width of the palette index held in the ROM.
- TRANSP_IDX, 0, palette index treated as transparent.
- V_ACTIVE, 480, number of visible lines; the frame boundary is at line V_ACTIVE.

Ports:
- vga_clk  in  1  pixel clock; all logic is on the posedge.
- reset  in  1  synchronous, active-high.
- DrawX  in  10  current pixel column.
- DrawY  in  10  current pixel row.
- blank  in  1  1 = active video.
- wr_en  in  1  write strobe for the slot shadow registers.
- wr_slot  in  $clog2(NUM_SLOTS)  target slot index.
- wr_x  in  10  sprite top-left column.
- wr_y  in  10  sprite top-left row.
- wr_dir  in  2  direction: 0 up, 1 right, 2 down, 3 left.
- wr_vis  in  1  slot visible.
- rom_addr  out  2*log2(SPRITE_W)  address to the sprite ROM; read latency is 1 cycle.
- rom_q  in  IDX_W  ROM data.
- pal_index  out  IDX_W  index to the combinational palette.
- pal_red, pal_green, pal_blue  in  4 each  palette colour.
- bg_red, bg_green, bg_blue  in  4 each  background colour, aligned to DrawX/DrawY.
- red, green, blue  out  4 each  final colour, registered.
- collide  out  NUM_SLOTS  per-slot collision flags; present only with the optional feature.

Behaviour:
- **Reset:**
  - All shadow and active slots are cleared: vis=0, x=y=0, dir=0.
  - All pipeline registers are cleared.
  - red/green/blue=0 and collide=0.
- **Shadow writes:** when wr_en=1, wr_x/y/dir/vis are written into shadow[wr_slot] on the edge. An out-of-range wr_slot is ignored.
- **Frame latch:**
  - The latch fires on the cycle where DrawX==0 && DrawY==V_ACTIVE.
  - On that cycle, active <= shadow for all slots.
  - A write on the same cycle lands in the shadow only. The latch copies the pre-write shadow, so the new value appears one frame later.
- **Stage 0 (combinational, cycle t):**
  - Hit test for slot i: vis && DrawX>=x && DrawX<x+SPRITE_W, with the same condition on Y.
  - The comparison uses 11-bit arithmetic so that x+SPRITE_W never wraps. A sprite at x=636 is clipped at the screen edge, not wrapped.
  - The lowest-index hitting slot wins.
  - dx=DrawX-x and dy=DrawY-y, taken over log2(SPRITE_W) bits. Let S=SPRITE_W-1.
  - Rotation to (u,v) by dir:
    - 0 up: u=dx, v=dy.
    - 1 right: u=dy, v=S-dx.
    - 2 down: u=S-dx, v=S-dy.
    - 3 left: u=S-dy, v=dx.
  - rom_addr = v*SPRITE_W+u. When there is no hit, rom_addr=0.
- **Stage 1 (t+1):**
  - rom_q is valid.
  - hit, blank and bg colour are delayed by one register.
  - pal_index = rom_q.
- **Stage 2 (t+2):** the output register loads as follows:
  - !blank_d -> 0.
  - hit_d && rom_q!=TRANSP_IDX -> palette colour.
  - otherwise -> bg_d.
- **Latency:** fixed at 2 vga_clk cycles from DrawX/DrawY/blank/bg to red/green/blue, with one pixel per clock.
- **Overlap:** where slots overlap, the lower-index slot owns the pixel, even if that slot's pixel is transparent. There is no fall-through to a higher-index slot.

Optional Feature:
- Macro: SPRITE_COLLIDE_EN.
- **Defined:**
  - An internal sticky accumulator sets bit i whenever slot i and at least one other slot both pass the stage-0 hit test (bounding-box overlap) on the same pixel while blank=1.
  - At the frame latch, collide <= accumulator and the accumulator is cleared.
  - collide therefore holds the previous frame's result for one full frame.
- **Undefined:** the collide port and the accumulator are absent.

Decomposition:
- Package sprite_slot_pkg holds:
  - typedef dir_t, an enum {DIR_UP, DIR_RIGHT, DIR_DOWN, DIR_LEFT}.
  - typedef slot_t, a packed struct {vis, x, y, dir}.
  - the constant COLOR_W=4.
- Sub-module sprite_slot_hit: per-slot combinational hit test plus rotation to (u,v), instantiated NUM_SLOTS times.

Test Plan:
- **Single slot, orientation:** slot0 = {x=100, y=50, dir=0, vis=1}; ROM holds pal index 1 only at address 0. After the frame latch, the pixel (100,50) appears on red/green/blue 2 cycles later with the palette colour; (101,50) shows the background.
- **Rotation:** same setup with dir=1, 2, 3. The coloured pixel moves to (107,50), (107,57) and (100,57) respectively.
- **Tear-free update:** write slot0 x=200 mid-frame (DrawY=240). Output does not change until after DrawX=0, DrawY=480. A write on exactly that cycle takes effect one frame later.
- **Clipping and priority:**
  - slot1 at x=636 is clipped with no wrap, and nothing is drawn at DrawX 0..3.
  - slot0 and slot1 fully overlapping with slot0 transparent at a pixel gives the background, not slot1.
- **Blank and reset:**
  - blank=0 drives outputs to 0 two cycles later.
  - reset asserted mid-frame clears all slots, so the next output shows the background only, and outputs read 0 during reset.
- **SPRITE_COLLIDE_EN:** slots 0 and 2 overlap at (300,300) and slot 1 is elsewhere. After the next frame latch collide=4'b0101; one frame after the slots separate, collide=0.
